// File: rtl/wb_pkg.sv
// Shared types for the writeback queue: entry layout, source tags and FSM encoding.
package wb_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned NUM_REGS = 1 << REG_W;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        GAP   = 2'b10
    } wb_state_e;

    typedef struct packed {
        logic              src;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer: up to two pushes and one pop per cycle, slots exposed for lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push0_valid_i,
    input  wb_entry_t                  push0_entry_i,
    input  logic                       push1_valid_i,
    input  wb_entry_t                  push1_entry_i,
    input  logic                       pop_i,
    output wb_entry_t                  slots_o [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // push1 is only ever valid together with push0, so it always lands one slot later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push0_valid_i) + PTR_W'(push1_valid_i);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
            count_q  <= count_q + CNT_W'(push0_valid_i) + CNT_W'(push1_valid_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clock) begin
        if (push0_valid_i) mem_q[wr_ptr_q] <= push0_entry_i;
        if (push1_valid_i) mem_q[wr_ptr_q + PTR_W'(1)] <= push1_entry_i;
    end

    assign slots_o  = mem_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/writeback_queue.sv
// Writeback stage: queues ALU/load results and issues pulsed single writes to the register file.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    input  logic [REG_W-1:0]     alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    input  logic [REG_W-1:0]     mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 wb_ready,
    output logic [REG_W-1:0]     RW,
    output logic [DATA_W-1:0]    BusW1,
    output logic [DATA_W-1:0]    BusW2,
    output logic                 sig_enable_write1,
    output logic                 sig_enable_write2,
    output logic [NUM_REGS-1:0]  pending_mask,
    input  logic [REG_W-1:0]     fwd_ra,
    input  logic [REG_W-1:0]     fwd_rb,
    output logic                 fwd_hit_a,
    output logic                 fwd_hit_b,
    output logic [DATA_W-1:0]    fwd_data_a,
    output logic [DATA_W-1:0]    fwd_data_b,
    output logic                 err_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_state_e          state_q, state_d;
    logic [REG_W-1:0]   rw_q, rw_d;
    logic [DATA_W-1:0]  busw1_q, busw1_d;
    logic [DATA_W-1:0]  busw2_q, busw2_d;
    logic               en1_q, en1_d;
    logic               en2_q, en2_d;
    logic               err_q;

    wb_entry_t          slots [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   idx;
    wb_entry_t          head;
    wb_entry_t          alu_entry, mem_entry, push0_entry;
    logic               alu_ok, mem_ok, drop, pop;

    assign wb_ready  = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
    assign alu_entry = '{src: SRC_ALU, rd: alu_rd, data: alu_data};
    assign mem_entry = '{src: SRC_MEM, rd: mem_rd, data: mem_data};

    // r0 writes are discarded outright; MEM is the older instruction and goes in first.
    assign alu_ok      = alu_valid && (alu_rd != '0) && wb_ready;
    assign mem_ok      = mem_valid && (mem_rd != '0) && wb_ready;
    assign drop        = ((alu_valid && (alu_rd != '0)) || (mem_valid && (mem_rd != '0))) && !wb_ready;
    assign push0_entry = mem_ok ? mem_entry : alu_entry;
    assign head        = slots[rd_ptr];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock         (clock),
        .reset_n       (reset_n),
        .push0_valid_i (mem_ok || alu_ok),
        .push0_entry_i (push0_entry),
        .push1_valid_i (mem_ok && alu_ok),
        .push1_entry_i (alu_entry),
        .pop_i         (pop),
        .slots_o       (slots),
        .rd_ptr_o      (rd_ptr),
        .count_o       (count)
    );

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        busw1_d = busw1_q;
        busw2_d = busw2_q;
        en1_d   = 1'b0;
        en2_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (count != '0) begin
                    state_d = WRITE;
                    pop     = 1'b1;
                    rw_d    = head.rd;
                    if (head.src == SRC_ALU) begin
                        busw1_d = head.data;
                        en1_d   = 1'b1;
                    end else begin
                        busw2_d = head.data;
                        en2_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rw_q    <= '0;
            busw1_q <= '0;
            busw2_q <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            busw1_q <= busw1_d;
            busw2_q <= busw2_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            err_q   <= err_q | drop;
        end
    end

    // Walk from head to tail so the youngest matching entry overrides older ones.
    always_comb begin
        pending_mask = '0;
        fwd_hit_a    = 1'b0;
        fwd_hit_b    = 1'b0;
        fwd_data_a   = '0;
        fwd_data_b   = '0;
        idx          = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                pending_mask[slots[idx].rd] = 1'b1;
                if ((fwd_ra != '0) && (slots[idx].rd == fwd_ra)) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = slots[idx].data;
                end
                if ((fwd_rb != '0) && (slots[idx].rd == fwd_rb)) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = slots[idx].data;
                end
            end
        end
    end

    assign RW                = rw_q;
    assign BusW1             = busw1_q;
    assign BusW2             = busw2_q;
    assign sig_enable_write1 = en1_q;
    assign sig_enable_write2 = en2_q;
    assign err_overflow      = err_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed table-driven bench for writeback_queue plus a hand-written mid-write reset sequence.
module tb_writeback_queue;

    logic        clock;
    logic        reset_n;
    logic        alu_valid, mem_valid;
    logic [2:0]  alu_rd, mem_rd;
    logic [15:0] alu_data, mem_data;
    logic        wb_ready;
    logic [2:0]  RW;
    logic [15:0] BusW1, BusW2;
    logic        sig_enable_write1, sig_enable_write2;
    logic [7:0]  pending_mask;
    logic [2:0]  fwd_ra, fwd_rb;
    logic        fwd_hit_a, fwd_hit_b;
    logic [15:0] fwd_data_a, fwd_data_b;
    logic        err_overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        av;
        logic [2:0]  ard;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  mrd;
        logic [15:0] md;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        e1;
        logic        e2;
        logic [2:0]  rw;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [7:0]  mask;
        logic        rdy;
        logic        ha;
        logic [15:0] da;
        logic        hb;
        logic [15:0] db;
        logic        err;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl [NVEC];

    writeback_queue dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .alu_valid         (alu_valid),
        .alu_rd            (alu_rd),
        .alu_data          (alu_data),
        .mem_valid         (mem_valid),
        .mem_rd            (mem_rd),
        .mem_data          (mem_data),
        .wb_ready          (wb_ready),
        .RW                (RW),
        .BusW1             (BusW1),
        .BusW2             (BusW2),
        .sig_enable_write1 (sig_enable_write1),
        .sig_enable_write2 (sig_enable_write2),
        .pending_mask      (pending_mask),
        .fwd_ra            (fwd_ra),
        .fwd_rb            (fwd_rb),
        .fwd_hit_a         (fwd_hit_a),
        .fwd_hit_b         (fwd_hit_b),
        .fwd_data_a        (fwd_data_a),
        .fwd_data_b        (fwd_data_b),
        .err_overflow      (err_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input int av, ard, ad, mv, mrd, md, ra, rb,
                                input int e1, e2, rw, b1, b2, mask, rdy, ha, da, hb, db, err);
        vec_t v;
        v.av = 1'(av);   v.ard = 3'(ard); v.ad = 16'(ad);
        v.mv = 1'(mv);   v.mrd = 3'(mrd); v.md = 16'(md);
        v.ra = 3'(ra);   v.rb = 3'(rb);
        v.e1 = 1'(e1);   v.e2 = 1'(e2);   v.rw = 3'(rw);
        v.b1 = 16'(b1);  v.b2 = 16'(b2);  v.mask = 8'(mask); v.rdy = 1'(rdy);
        v.ha = 1'(ha);   v.da = 16'(da);  v.hb = 1'(hb);     v.db = 16'(db);
        v.err = 1'(err);
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp_v);
        end
    endtask

    task automatic check_row(input vec_t v, input int row);
        chk("en1",     row, 16'(sig_enable_write1), 16'(v.e1));
        chk("en2",     row, 16'(sig_enable_write2), 16'(v.e2));
        chk("overlap", row, 16'(sig_enable_write1 & sig_enable_write2), 16'(0));
        chk("RW",      row, 16'(RW), 16'(v.rw));
        chk("BusW1",   row, BusW1, v.b1);
        chk("BusW2",   row, BusW2, v.b2);
        chk("mask",    row, 16'(pending_mask), 16'(v.mask));
        chk("ready",   row, 16'(wb_ready), 16'(v.rdy));
        chk("hit_a",   row, 16'(fwd_hit_a), 16'(v.ha));
        chk("data_a",  row, fwd_data_a, v.da);
        chk("hit_b",   row, 16'(fwd_hit_b), 16'(v.hb));
        chk("data_b",  row, fwd_data_b, v.db);
        chk("err",     row, 16'(err_overflow), 16'(v.err));
    endtask

    task automatic drive(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                         input logic mv, input logic [2:0] mrd, input logic [15:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Columns: alu v/rd/data, mem v/rd/data, ra, rb | en1 en2 RW BusW1 BusW2 mask ready hitA dataA hitB dataB err
        tbl[0]  = mk(1,3,'h1234, 0,0,0,       3,0, 0,0,0,0,0,'h08,1, 1,'h1234,0,0,0);
        tbl[1]  = mk(0,0,0,      0,0,0,       3,0, 1,0,3,'h1234,0,0,1, 0,0,0,0,0);
        tbl[2]  = mk(0,0,0,      0,0,0,       0,0, 0,0,3,'h1234,0,0,1, 0,0,0,0,0);
        tbl[3]  = mk(0,0,0,      0,0,0,       0,0, 0,0,3,'h1234,0,0,1, 0,0,0,0,0);
        tbl[4]  = mk(1,0,'hFFFF, 0,0,0,       0,0, 0,0,3,'h1234,0,0,1, 0,0,0,0,0);
        tbl[5]  = mk(0,0,0,      0,0,0,       0,0, 0,0,3,'h1234,0,0,1, 0,0,0,0,0);
        tbl[6]  = mk(1,5,'h5555, 1,2,'hAAAA,  5,2, 0,0,3,'h1234,0,'h24,1, 1,'h5555,1,'hAAAA,0);
        tbl[7]  = mk(0,0,0,      0,0,0,       5,2, 0,1,2,'h1234,'hAAAA,'h20,1, 1,'h5555,0,0,0);
        tbl[8]  = mk(0,0,0,      0,0,0,       0,0, 0,0,2,'h1234,'hAAAA,'h20,1, 0,0,0,0,0);
        tbl[9]  = mk(0,0,0,      0,0,0,       0,0, 1,0,5,'h5555,'hAAAA,0,1, 0,0,0,0,0);
        tbl[10] = mk(0,0,0,      0,0,0,       0,0, 0,0,5,'h5555,'hAAAA,0,1, 0,0,0,0,0);
        tbl[11] = mk(0,0,0,      0,0,0,       0,0, 0,0,5,'h5555,'hAAAA,0,1, 0,0,0,0,0);
        tbl[12] = mk(1,7,'h0777, 0,0,0,       0,0, 0,0,5,'h5555,'hAAAA,'h80,1, 0,0,0,0,0);
        tbl[13] = mk(1,4,'h1111, 0,0,0,       0,0, 1,0,7,'h0777,'hAAAA,'h10,1, 0,0,0,0,0);
        tbl[14] = mk(0,0,0,      1,4,'h2222,  4,0, 0,0,7,'h0777,'hAAAA,'h10,1, 1,'h2222,0,0,0);
        tbl[15] = mk(0,0,0,      0,0,0,       4,0, 1,0,4,'h1111,'hAAAA,'h10,1, 1,'h2222,0,0,0);
        tbl[16] = mk(0,0,0,      0,0,0,       0,0, 0,0,4,'h1111,'hAAAA,'h10,1, 0,0,0,0,0);
        tbl[17] = mk(0,0,0,      0,0,0,       0,0, 0,1,4,'h1111,'h2222,0,1, 0,0,0,0,0);
        tbl[18] = mk(0,0,0,      0,0,0,       0,0, 0,0,4,'h1111,'h2222,0,1, 0,0,0,0,0);
        tbl[19] = mk(0,0,0,      0,0,0,       0,0, 0,0,4,'h1111,'h2222,0,1, 0,0,0,0,0);
        tbl[20] = mk(1,2,'h0202, 1,1,'h0101,  0,0, 0,0,4,'h1111,'h2222,'h06,1, 0,0,0,0,0);
        tbl[21] = mk(1,6,'h0606, 1,3,'h0303,  0,0, 0,1,1,'h1111,'h0101,'h4C,0, 0,0,0,0,0);
        tbl[22] = mk(1,6,'h0666, 0,0,0,       6,0, 0,0,1,'h1111,'h0101,'h4C,0, 1,'h0606,0,0,1);
        tbl[23] = mk(0,0,0,      0,0,0,       0,0, 1,0,2,'h0202,'h0101,'h48,1, 0,0,0,0,1);
        tbl[24] = mk(0,0,0,      0,0,0,       0,0, 0,0,2,'h0202,'h0101,'h48,1, 0,0,0,0,1);
        tbl[25] = mk(0,0,0,      0,0,0,       0,0, 0,1,3,'h0202,'h0303,'h40,1, 0,0,0,0,1);
        tbl[26] = mk(0,0,0,      0,0,0,       0,0, 0,0,3,'h0202,'h0303,'h40,1, 0,0,0,0,1);
        tbl[27] = mk(0,0,0,      0,0,0,       0,0, 1,0,6,'h0606,'h0303,0,1, 0,0,0,0,1);
        tbl[28] = mk(0,0,0,      0,0,0,       0,0, 0,0,6,'h0606,'h0303,0,1, 0,0,0,0,1);
        tbl[29] = mk(0,0,0,      0,0,0,       0,0, 0,0,6,'h0606,'h0303,0,1, 0,0,0,0,1);

        reset_n = 1'b0;
        fwd_ra  = '0;
        fwd_rb  = '0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        check_row(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0), -1);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
            fwd_ra = tbl[i].ra;
            fwd_rb = tbl[i].rb;
            step();
            check_row(tbl[i], i);
        end

        // Asynchronous reset in the middle of a write pulse, with a second entry still queued.
        fwd_ra = '0;
        fwd_rb = '0;
        drive(1, 5, 16'h0BEE, 1, 1, 16'h0011);
        step();
        chk("rst_seq_mask_pre", 100, 16'(pending_mask), 16'h0022);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("rst_seq_en2_on", 101, 16'(sig_enable_write2), 16'(1));
        chk("rst_seq_rw_on",  101, 16'(RW), 16'(1));
        chk("rst_seq_b2_on",  101, BusW2, 16'h0011);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_en1",  102, 16'(sig_enable_write1), 16'(0));
        chk("rst_async_en2",  102, 16'(sig_enable_write2), 16'(0));
        chk("rst_async_rw",   102, 16'(RW), 16'(0));
        chk("rst_async_b1",   102, BusW1, 16'h0000);
        chk("rst_async_b2",   102, BusW2, 16'h0000);
        chk("rst_async_mask", 102, 16'(pending_mask), 16'h0000);
        chk("rst_async_rdy",  102, 16'(wb_ready), 16'(1));
        chk("rst_async_err",  102, 16'(err_overflow), 16'(0));
        step();
        reset_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            step();
            chk("post_rst_en1",  103 + j, 16'(sig_enable_write1), 16'(0));
            chk("post_rst_en2",  103 + j, 16'(sig_enable_write2), 16'(0));
            chk("post_rst_mask", 103 + j, 16'(pending_mask), 16'h0000);
        end
        drive(1, 3, 16'h3333, 0, 0, 0);
        step();
        chk("post_rst_mask_q", 105, 16'(pending_mask), 16'h0008);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_en1_on", 106, 16'(sig_enable_write1), 16'(1));
        chk("post_rst_rw",     106, 16'(RW), 16'(3));
        chk("post_rst_b1",     106, BusW1, 16'h3333);
        step();
        chk("post_rst_en1_off", 107, 16'(sig_enable_write1), 16'(0));
        chk("post_rst_rw_hold", 107, 16'(RW), 16'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
